// File: rtl/control_unit.sv
// Hardwired Moore sequencer for the datapath: fetch in T0-T2, then an opcode-specific
// execute sequence in T3-T7. Every strobe is a pure decode of state, IR[31:27] and CON_FF.
module control_unit #(
  parameter logic [3:0] ALU_ADD = 4'd2,
  parameter logic [3:0] ALU_SUB = 4'd3,
  parameter logic [3:0] ALU_AND = 4'd4,
  parameter logic [3:0] ALU_OR  = 4'd5
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  output logic        PCout,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        MDRout,
  output logic        highout,
  output logic        lowout,
  output logic        inPortOut,
  output logic        Cout,
  output logic        BAout,
  output logic        Rout,
  output logic        MARin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        Rin,
  output logic        highin,
  output logic        lowin,
  output logic        outPortIn,
  output logic        con_in,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        IncPC,
  output logic        Read,
  output logic        ram_enable,
  output logic        R15_enable,
  output logic [3:0]  CONTROL,
  output logic        Run
);

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_BR   = 5'b10010;
  localparam logic [4:0] OP_JR   = 5'b10011;
  localparam logic [4:0] OP_JAL  = 5'b10100;
  localparam logic [4:0] OP_IN   = 5'b10101;
  localparam logic [4:0] OP_OUT  = 5'b10110;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_HALT = 5'b11010;

  typedef enum logic [3:0] {
    S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
  } state_t;

  state_t     state_reg;
  state_t     state_next;
  logic [4:0] opcode;
  logic [3:0] alu_op;

  assign opcode = IR[31:27];

  // ALU code for the register and immediate arithmetic/logic forms
  always_comb begin
    alu_op = ALU_ADD;
    case (opcode)
      OP_SUB:           alu_op = ALU_SUB;
      OP_AND, OP_ANDI:  alu_op = ALU_AND;
      OP_OR,  OP_ORI:   alu_op = ALU_OR;
      default:          alu_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Clear) state_reg <= S_RST;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0; highout = 1'b0;
    lowout = 1'b0; inPortOut = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
    MARin = 1'b0; Zlowin = 1'b0; Zhighin = 1'b0; PCin = 1'b0; MDRin = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Rin = 1'b0; highin = 1'b0; lowin = 1'b0;
    outPortIn = 1'b0; con_in = 1'b0; Gra = 1'b0; Grb = 1'b0; Grc = 1'b0;
    IncPC = 1'b0; Read = 1'b0; ram_enable = 1'b0; R15_enable = 1'b0;
    CONTROL = 4'd0;
    Run = 1'b0;

    case (state_reg)
      S_RST: state_next = S_T0;
      S_T0: begin
        Run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
        state_next = S_T1;
      end
      S_T1: begin
        Run = 1'b1; Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
        state_next = S_T2;
      end
      S_T2: begin
        Run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
        state_next = S_T3;
      end
      S_T3: begin
        Run = 1'b1;
        state_next = S_T0;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI: begin
            Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; state_next = S_T4;
          end
          OP_LDI, OP_LD, OP_ST: begin
            Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; state_next = S_T4;
          end
          OP_BR: begin
            Gra = 1'b1; Rout = 1'b1; con_in = 1'b1; state_next = S_T4;
          end
          OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          OP_JAL:  begin PCout = 1'b1; R15_enable = 1'b1; state_next = S_T4; end
          OP_IN:   begin inPortOut = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; outPortIn = 1'b1; end
          OP_MFHI: begin highout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_MFLO: begin lowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_HALT: state_next = S_HALT;
          default: state_next = S_T0;
        endcase
      end
      S_T4: begin
        Run = 1'b1;
        state_next = S_T5;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            Grc = 1'b1; Rout = 1'b1; Zlowin = 1'b1; CONTROL = alu_op;
          end
          OP_ADDI, OP_ANDI, OP_ORI: begin
            Cout = 1'b1; Zlowin = 1'b1; CONTROL = alu_op;
          end
          OP_LDI, OP_LD, OP_ST: begin
            Cout = 1'b1; Zlowin = 1'b1; CONTROL = ALU_ADD;
          end
          OP_BR:  begin PCout = 1'b1; Yin = 1'b1; end
          OP_JAL: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; state_next = S_T0; end
          default: state_next = S_T0;
        endcase
      end
      S_T5: begin
        Run = 1'b1;
        state_next = S_T0;
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
            Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          OP_LD, OP_ST: begin
            Zlowout = 1'b1; MARin = 1'b1; state_next = S_T6;
          end
          OP_BR: begin
            Cout = 1'b1; Zlowin = 1'b1; CONTROL = ALU_ADD; state_next = S_T6;
          end
          default: state_next = S_T0;
        endcase
      end
      S_T6: begin
        Run = 1'b1;
        state_next = S_T0;
        case (opcode)
          OP_LD: begin Read = 1'b1; MDRin = 1'b1; state_next = S_T7; end
          OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; state_next = S_T7; end
          // Branch target is already in Z; only the condition decides whether PC takes it
          OP_BR: begin Zlowout = 1'b1; PCin = CON_FF; end
          default: state_next = S_T0;
        endcase
      end
      S_T7: begin
        Run = 1'b1;
        state_next = S_T0;
        case (opcode)
          OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          OP_ST:   ram_enable = 1'b1;
          default: state_next = S_T0;
        endcase
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_RST;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: an instruction-sequence model checked every cycle,
// plus hand-computed literal expectations at key steps.
module tb_control_unit;

  logic        Clock = 1'b0;
  logic        Clear = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        CON_FF = 1'b0;
  logic PCout, Zlowout, Zhighout, MDRout, highout, lowout, inPortOut, Cout, BAout, Rout;
  logic MARin, Zlowin, Zhighin, PCin, MDRin, IRin, Yin, Rin, highin, lowin, outPortIn, con_in;
  logic Gra, Grb, Grc, IncPC, Read, ram_enable, R15_enable, Run;
  logic [3:0] CONTROL;

  always #5 Clock = ~Clock;

  control_unit dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF),
    .PCout(PCout), .Zlowout(Zlowout), .Zhighout(Zhighout), .MDRout(MDRout),
    .highout(highout), .lowout(lowout), .inPortOut(inPortOut), .Cout(Cout),
    .BAout(BAout), .Rout(Rout), .MARin(MARin), .Zlowin(Zlowin), .Zhighin(Zhighin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .Rin(Rin), .highin(highin),
    .lowin(lowin), .outPortIn(outPortIn), .con_in(con_in), .Gra(Gra), .Grb(Grb),
    .Grc(Grc), .IncPC(IncPC), .Read(Read), .ram_enable(ram_enable),
    .R15_enable(R15_enable), .CONTROL(CONTROL), .Run(Run)
  );

  logic [33:0] dut_vec;
  assign dut_vec = {Run, CONTROL, R15_enable, ram_enable, Read, IncPC, Grc, Grb, Gra,
                    con_in, outPortIn, lowin, highin, Rin, Yin, IRin, MDRin, PCin,
                    Zhighin, Zlowin, MARin, Rout, BAout, Cout, inPortOut, lowout,
                    highout, MDRout, Zhighout, Zlowout, PCout};

  localparam logic [33:0] PCOUT = 34'd1 << 0,  ZLOWOUT = 34'd1 << 1,  MDROUT = 34'd1 << 3;
  localparam logic [33:0] HIGHOUT = 34'd1 << 4, LOWOUT = 34'd1 << 5, INPORTOUT = 34'd1 << 6;
  localparam logic [33:0] COUT = 34'd1 << 7,   BAOUT = 34'd1 << 8,    ROUT = 34'd1 << 9;
  localparam logic [33:0] MARIN = 34'd1 << 10, ZLOWIN = 34'd1 << 11,  PCIN = 34'd1 << 13;
  localparam logic [33:0] MDRIN = 34'd1 << 14, IRIN = 34'd1 << 15,    YIN = 34'd1 << 16;
  localparam logic [33:0] RIN = 34'd1 << 17,   OUTPORTIN = 34'd1 << 20, CONIN = 34'd1 << 21;
  localparam logic [33:0] GRA = 34'd1 << 22,   GRB = 34'd1 << 23,     GRC = 34'd1 << 24;
  localparam logic [33:0] INCPC = 34'd1 << 25, READ = 34'd1 << 26,    RAMEN = 34'd1 << 27;
  localparam logic [33:0] R15EN = 34'd1 << 28, RUNM = 34'd1 << 33;
  localparam logic [33:0] T0_VEC = RUNM | PCOUT | MARIN | INCPC | ZLOWIN;

  localparam int M_RESET = 0, M_RUN = 1, M_HALT = 2;

  int errors = 0;
  int checks = 0;

  function automatic logic [33:0] ctl(input logic [3:0] c);
    return 34'(c) << 29;
  endfunction

  // Total cycles an instruction occupies, fetch included (halt handled separately)
  function automatic int instr_len(input logic [4:0] op);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b01100, 5'b01101, 5'b01110, 5'b00001: return 6;
      5'b00000, 5'b00010: return 8;
      5'b10010: return 7;
      5'b10100: return 5;
      default:  return 4;
    endcase
  endfunction

  function automatic logic [3:0] alu_code(input logic [4:0] op);
    case (op)
      5'b00100:           return 4'd3;
      5'b00101, 5'b01101: return 4'd4;
      5'b00110, 5'b01110: return 4'd5;
      default:            return 4'd2;
    endcase
  endfunction

  // Strobes for execute step k (k=0 is the first step after fetch) of instruction op
  function automatic logic [33:0] exec_step(input logic [4:0] op, input int k, input logic con);
    logic [33:0] seq [0:4];
    for (int i = 0; i < 5; i++) seq[i] = '0;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        seq[0] = GRB | ROUT | YIN;
        seq[1] = GRC | ROUT | ZLOWIN | ctl(alu_code(op));
        seq[2] = ZLOWOUT | GRA | RIN;
      end
      5'b01100, 5'b01101, 5'b01110: begin
        seq[0] = GRB | ROUT | YIN;
        seq[1] = COUT | ZLOWIN | ctl(alu_code(op));
        seq[2] = ZLOWOUT | GRA | RIN;
      end
      5'b00001, 5'b00000, 5'b00010: begin
        seq[0] = GRB | BAOUT | YIN;
        seq[1] = COUT | ZLOWIN | ctl(4'd2);
        seq[2] = (op == 5'b00001) ? (ZLOWOUT | GRA | RIN) : (ZLOWOUT | MARIN);
        seq[3] = (op == 5'b00000) ? (READ | MDRIN) : (GRA | ROUT | MDRIN);
        seq[4] = (op == 5'b00000) ? (MDROUT | GRA | RIN) : RAMEN;
      end
      5'b10010: begin
        seq[0] = GRA | ROUT | CONIN;
        seq[1] = PCOUT | YIN;
        seq[2] = COUT | ZLOWIN | ctl(4'd2);
        seq[3] = ZLOWOUT | (con ? PCIN : 34'd0);
      end
      5'b10011: seq[0] = GRA | ROUT | PCIN;
      5'b10100: begin seq[0] = PCOUT | R15EN; seq[1] = GRA | ROUT | PCIN; end
      5'b10101: seq[0] = INPORTOUT | GRA | RIN;
      5'b10110: seq[0] = GRA | ROUT | OUTPORTIN;
      5'b10111: seq[0] = HIGHOUT | GRA | RIN;
      5'b11000: seq[0] = LOWOUT | GRA | RIN;
      default: ;
    endcase
    return (k >= 0 && k < 5) ? seq[k] : 34'd0;
  endfunction

  function automatic logic [33:0] expect_out(input int mode, input int step,
                                             input logic [4:0] op, input logic con);
    if (mode != M_RUN) return '0;
    case (step)
      0:       return T0_VEC;
      1:       return RUNM | ZLOWOUT | PCIN | READ | MDRIN;
      2:       return RUNM | MDROUT | IRIN;
      default: return RUNM | exec_step(op, step - 3, con);
    endcase
  endfunction

  // Model: mode plus position within the current instruction
  int m_mode = -1;
  int m_step = 0;

  always @(posedge Clock) begin
    if (Clear) begin
      m_mode <= M_RESET;
      m_step <= 0;
    end else begin
      case (m_mode)
        M_RESET: begin m_mode <= M_RUN; m_step <= 0; end
        M_RUN: begin
          if (m_step == 3 && IR[31:27] == 5'b11010) m_mode <= M_HALT;
          else if (m_step + 1 >= instr_len(IR[31:27])) m_step <= 0;
          else m_step <= m_step + 1;
        end
        default: ;
      endcase
    end
  end

  always @(negedge Clock) begin
    if (m_mode >= 0) begin
      logic [33:0] exp_v;
      exp_v = expect_out(m_mode, m_step, IR[31:27], CON_FF);
      checks++;
      if (dut_vec !== exp_v) begin
        errors++;
        $display("FAIL cycle_model t=%0t mode=%0d step=%0d IR=%h got=%h want=%h",
                 $time, m_mode, m_step, IR, dut_vec, exp_v);
      end
    end
  end

  task automatic check(input string name, input logic [33:0] got, input logic [33:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  logic [33:0] snap [0:23];
  int          n_end;
  bit          ram_seen;

  // Starts at T0 (#1 after its edge); IR carries ir_fetch through fetch and ir from T2 on.
  task automatic run_instr(input logic [31:0] ir_fetch, input logic [31:0] ir, input logic con,
                           input int clear_at, input int max_n);
    IR = ir_fetch;
    CON_FF = con;
    n_end = 0;
    ram_seen = 1'b0;
    snap[0] = dut_vec;
    for (int n = 1; n <= max_n; n++) begin
      @(posedge Clock); #1;
      snap[n] = dut_vec;
      if ((dut_vec & RAMEN) != 0) ram_seen = 1'b1;
      if (n == 2) IR = ir;
      if (clear_at > 0 && n == clear_at) Clear = 1'b1;
      if (clear_at > 0 && n == clear_at + 2) Clear = 1'b0;
      if ((dut_vec & (PCOUT | MARIN | INCPC)) == (PCOUT | MARIN | INCPC)) begin
        n_end = n;
        break;
      end
    end
    $display("instr IR=%h con=%0b clear_at=%0d cycles=%0d", ir, con, clear_at, n_end);
  endtask

  initial begin
    Clear = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_outputs", dut_vec, 34'd0);
    Clear = 1'b0;
    @(posedge Clock); #1;
    check("first_t0", dut_vec, T0_VEC);

    run_instr(32'h19890000, 32'h19890000, 1'b0, 0, 20);
    check("add_len", 34'(n_end), 34'd6);
    check("add_t4", snap[4], RUNM | GRC | ROUT | ZLOWIN | ctl(4'd2));
    check("add_t5", snap[5], RUNM | ZLOWOUT | GRA | RIN);

    run_instr(32'h91000023, 32'h91000023, 1'b1, 0, 20);
    check("br_taken_len", 34'(n_end), 34'd7);
    check("br_taken_t6", snap[6], RUNM | ZLOWOUT | PCIN);
    run_instr(32'h91000023, 32'h91000023, 1'b0, 0, 20);
    check("br_nottaken_len", 34'(n_end), 34'd7);
    check("br_nottaken_t6", snap[6], RUNM | ZLOWOUT);

    run_instr(32'hC8000000, 32'hC8000000, 1'b0, 0, 20);
    check("nop_len", 34'(n_end), 34'd4);
    check("nop_t3", snap[3], RUNM);
    run_instr(32'hF8000000, 32'hF8000000, 1'b0, 0, 20);
    check("undef_len", 34'(n_end), 34'd4);
    check("undef_t3", snap[3], RUNM);

    // A halt opcode seen only during fetch must not matter; sub is decoded from T3
    run_instr(32'hD0000000, 32'h20000000, 1'b0, 0, 20);
    check("sub_len", 34'(n_end), 34'd6);
    check("sub_t4", snap[4], RUNM | GRC | ROUT | ZLOWIN | ctl(4'd3));

    run_instr(32'h08000000, 32'h08000000, 1'b0, 0, 20);
    check("ldi_t3", snap[3], RUNM | GRB | BAOUT | YIN);
    run_instr(32'h70000000, 32'h70000000, 1'b0, 0, 20);
    check("ori_t4", snap[4], RUNM | COUT | ZLOWIN | ctl(4'd5));
    run_instr(32'h00000000, 32'h00000000, 1'b0, 0, 20);
    check("ld_len", 34'(n_end), 34'd8);
    check("ld_t7", snap[7], RUNM | MDROUT | GRA | RIN);
    run_instr(32'hA0000000, 32'hA0000000, 1'b0, 0, 20);
    check("jal_len", 34'(n_end), 34'd5);
    check("jal_t3", snap[3], RUNM | PCOUT | R15EN);
    run_instr(32'hB8000000, 32'hB8000000, 1'b0, 0, 20);
    check("mfhi_len", 34'(n_end), 34'd4);

    run_instr(32'h10000000, 32'h10000000, 1'b0, 0, 20);
    check("st_len", 34'(n_end), 34'd8);
    check("st_t7", snap[7], RUNM | RAMEN);

    run_instr(32'h10000000, 32'h10000000, 1'b0, 6, 20);
    check("st_clear_rst", snap[7], 34'd0);
    check("st_clear_no_write", 34'(ram_seen), 34'd0);
    check("st_clear_restart", 34'(n_end), 34'd9);

    run_instr(32'hD0000000, 32'hD0000000, 1'b0, 0, 16);
    check("halt_no_t0", 34'(n_end), 34'd0);
    check("halt_t4", snap[4], 34'd0);
    check("halt_hold", snap[16], 34'd0);
    Clear = 1'b1;
    @(posedge Clock); #1;
    check("halt_clear_rst", dut_vec, 34'd0);
    Clear = 1'b0;
    @(posedge Clock); #1;
    check("halt_clear_t0", dut_vec, T0_VEC);

    @(negedge Clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
